rotate_sequencer: RTL and testbench

//  Sequences an N-bit rotate-by-M datapath through a programmed number of steps.

---
 rtl/rotate_sequencer.sv | 138 +++++++++++++
 tb/tb_rotate_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rotate_sequencer.sv
// Step sequencer around a rotate-by-M datapath.
// Streams each rotated word on a valid/ready output.
module rotate_sequencer #(
  parameter int N  = 8,
  parameter int M  = 3,
  parameter int SW = 4
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          start,
  input  logic [N-1:0]  din,
  input  logic          dir,
  input  logic [SW-1:0] steps,
  input  logic          abort,
  output logic          busy,
  output logic [N-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          done
);

  localparam int MP = M % N;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic [N-1:0]  dout_q, dout_d;
  logic [SW-1:0] rem_q, rem_d;
  logic          dir_q, dir_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          adv, fin;
  logic [N-1:0]  rot_w;

  // doubling the word makes a zero distance fall out as identity
  function automatic logic [N-1:0] rot(
    input logic [N-1:0] x,
    input logic         r
  );
    logic [2*N-1:0] dbl;
    dbl = {x, x};
    if (r) begin
      dbl = dbl >> MP;
      rot = dbl[N-1:0];
    end else begin
      dbl = dbl << MP;
      rot = dbl[2*N-1:N];
    end
  endfunction

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      work_q  <= '0;
      dout_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    rot_w   = rot(work_q, dir_q);
    adv     = (!valid_q || dout_ready) && (rem_q != '0);
    fin     = valid_q && dout_ready && last_q;
    state_d = state_q;
    work_d  = work_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            dir_d   = dir;
            work_d  = din;
            rem_d   = steps;
            if (steps == '0) begin
              dout_d  = din;
              valid_d = 1'b1;
              last_d  = 1'b1;
            end
          end
        end
        RUN: begin
          unique case (1'b1)
            fin: begin
              state_d = IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end
            adv: begin
              work_d  = rot_w;
              dout_d  = rot_w;
              valid_d = 1'b1;
              last_d  = (rem_q == SW'(1));
              rem_d   = rem_q - SW'(1);
            end
            default: ;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    dout       = dout_q;
    dout_valid = valid_q;
    dout_last  = last_q;
    done       = done_q;
  end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Scoreboard bench for rotate_sequencer.
// Stimulus pushes expected beats; a monitor pops on handshake.
module tb_rotate_sequencer;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = '0;
  logic       dir = 1'b0;
  logic [3:0] steps = '0;
  logic       abort = 1'b0;
  logic       busy;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       dout_last;
  logic       done;

  int checks = 0;
  int errors = 0;
  int dones  = 0;
  logic pend = 1'b0;
  logic [8:0] sb[$];

  rotate_sequencer #(.N(8), .M(3), .SW(4)) dut (
    .CLK(CLK), .nRESET(nRESET), .start(start), .din(din),
    .dir(dir), .steps(steps), .abort(abort), .busy(busy),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    sb.push_back({l, d});
  endtask

  task automatic issue(input logic [7:0] d, input logic r,
                       input logic [3:0] s);
    tick();
    din = d; dir = r; steps = s; start = 1'b1;
    tick();
    start = 1'b0; din = 8'h00; steps = 4'd0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_idle"}, busy, 1'b0);
  endtask

  // monitor: handshakes and done pulses
  always @(negedge CLK) begin
    if (done || pend) chk("done", done, pend);
    if (done) dones++;
    pend <= 1'b0;
    if (nRESET && dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", dout, 9'h1ff);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("beat", {dout_last, dout}, e);
        if (dout_last) pend <= 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    tick();
    nRESET = 1'b1;
    tick();

    // right by 3, two steps
    dout_ready = 1'b1;
    push(8'b10010101, 0);
    push(8'b10110010, 1);
    issue(8'b10101100, 1'b1, 4'd2);
    wait_idle("t1");
    tick();

    // left by 3, single step
    push(8'b01100101, 1);
    issue(8'b10101100, 1'b0, 4'd1);
    wait_idle("t2");
    tick();
    chk("t2_hold_dout", dout, 8'b01100101);
    chk("t2_valid_low", dout_valid, 0);

    // eight steps: three full turns
    push(8'b10010101, 0);
    push(8'b10110010, 0);
    push(8'b01010110, 0);
    push(8'b11001010, 0);
    push(8'b01011001, 0);
    push(8'b00101011, 0);
    push(8'b01100101, 0);
    push(8'b10101100, 1);
    issue(8'b10101100, 1'b1, 4'd8);
    wait_idle("t3");
    tick();

    // zero steps passes din through
    push(8'hA5, 1);
    issue(8'hA5, 1'b1, 4'd0);
    chk("t4_valid", dout_valid, 1);
    chk("t4_last", dout_last, 1);
    wait_idle("t4");
    tick();

    // backpressure, with an ignored start while busy
    dout_ready = 1'b0;
    push(8'b10010101, 0);
    push(8'b10110010, 0);
    push(8'b01010110, 1);
    issue(8'b10101100, 1'b1, 4'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold", dout, 8'b10010101);
      chk("t5_hold_valid", dout_valid, 1);
      chk("t5_hold_last", dout_last, 0);
      if (i == 1) begin
        start = 1'b1; din = 8'hFF; dir = 1'b0; steps = 4'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    dout_ready = 1'b1;
    wait_idle("t5");
    tick();

    // abort after first beat presented
    dout_ready = 1'b0;
    issue(8'b10101100, 1'b1, 4'd5);
    tick();
    chk("t6_beat1", dout, 8'b10010101);
    abort = 1'b1; start = 1'b1; din = 8'h11; steps = 4'd2;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("t6_abort_valid", dout_valid, 0);
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_last", dout_last, 0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("t6_abort_prio", busy, 0);
    tick();
    tick();

    // async reset mid-run
    dout_ready = 1'b1;
    push(8'b10010101, 0);
    issue(8'b10101100, 1'b1, 4'd5);
    tick();
    tick();
    nRESET = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", dout_valid, 0);
    chk("t6_rst_last", dout_last, 0);
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_done", done, 0);
    tick();
    nRESET = 1'b1;
    tick();
    tick();

    chk("sb_empty", sb.size(), 0);
    chk("done_count", dones, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
